seven_segment_capture_decoder: RTL and testbench

Passive monitor on the time-multiplexed 4-digit seven-segment bus (active-low anodes, active-low segments a..g on bits 6..0). It samples Anode/LED_out, debounces each digit slot, decodes segment patterns back to BCD and assembles a full 4-digit frame. A sequential multiply-accumulate then converts the frame to binary. Used for on-chip self-check and testbench scoreboarding of the display path, so the displayed value can be compared against the CPU's 13-bit display value.

---
 rtl/seven_segment_capture_decoder_if.sv | 32 +++
 rtl/seven_segment_capture_decoder.sv | 239 +++++++++++++++++++++++
 tb/tb_seven_segment_capture_decoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_capture_decoder_if.sv
// Seven-segment display bus as seen by the capture decoder.
// master: the display driver (drives Anode/LED_out, observes results).
// slave:  the capture decoder (observes the bus, drives results).
interface seven_segment_capture_decoder_if;
  logic [3:0]  Anode;
  logic [6:0]  LED_out;
  logic [13:0] num_out;
  logic        num_valid;
  logic        changed;
  logic        seg_err;
  logic        range_err;

  modport master (
    output Anode,
    output LED_out,
    input  num_out,
    input  num_valid,
    input  changed,
    input  seg_err,
    input  range_err
  );

  modport slave (
    input  Anode,
    input  LED_out,
    output num_out,
    output num_valid,
    output changed,
    output seg_err,
    output range_err
  );
endinterface

// File: rtl/seven_segment_capture_decoder.sv
// Passive monitor of a multiplexed 4-digit seven-segment bus. Debounces each digit slot,
// decodes segments back to BCD, assembles a frame and converts it to binary with a
// sequential multiply-accumulate.
module seven_segment_capture_decoder #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic                           clk,
  input logic                           rst,
  seven_segment_capture_decoder_if.slave bus
);

  localparam logic [7:0] SettleVal = SETTLE_CYCLES[7:0];

  typedef enum logic [0:0] {StCollect, StConvert} state_e;

  // Slot decode: index 0 = thousands ... 3 = ones
  logic       w_slot_legal;
  logic [1:0] w_slot_idx;

  // Segment decode
  logic [3:0] w_seg_digit;
  logic       w_seg_bad;

  // Stability tracking
  logic [3:0] r_anode_prev;
  logic [6:0] r_seg_prev;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_d;
  logic       w_same;
  logic       w_capture;

  // Frame collection
  logic [3:0] r_digit [4];
  logic [3:0] r_seen;
  logic [3:0] w_seen_d;
  logic       r_err_sticky;
  logic       w_err_sticky_d;
  logic       w_frame_start;

  // Conversion FSM and datapath
  state_e      r_state;
  state_e      w_state_d;
  logic [3:0]  r_snap [4];
  logic        r_snap_err;
  logic [13:0] r_acc;
  logic [13:0] w_acc_d;
  logic [1:0]  r_step;
  logic [1:0]  w_step_d;
  logic [13:0] w_mac;

  // Output registers
  logic [13:0] r_num_out;
  logic [13:0] w_num_out_d;
  logic        r_num_valid;
  logic        w_num_valid_d;
  logic        r_changed;
  logic        w_changed_d;
  logic        r_seg_err;
  logic        w_seg_err_d;
  logic        r_range_err;
  logic        w_range_err_d;
  logic        r_first;
  logic        w_first_d;

  // Map the active-low anode pattern to a digit slot; anything else is not a slot.
  always_comb begin
    w_slot_legal = 1'b1;
    w_slot_idx   = 2'd0;
    case (bus.Anode)
      4'b0111: w_slot_idx = 2'd0;
      4'b1011: w_slot_idx = 2'd1;
      4'b1101: w_slot_idx = 2'd2;
      4'b1110: w_slot_idx = 2'd3;
      default: w_slot_legal = 1'b0;
    endcase
  end

  // Decode active-low segments (a..g on bits 6..0) back to BCD.
  always_comb begin
    w_seg_digit = 4'd0;
    w_seg_bad   = 1'b0;
    case (bus.LED_out)
      7'b0000001: w_seg_digit = 4'd0;
      7'b1001111: w_seg_digit = 4'd1;
      7'b0010010: w_seg_digit = 4'd2;
      7'b0000110: w_seg_digit = 4'd3;
      7'b1001100: w_seg_digit = 4'd4;
      7'b0100100: w_seg_digit = 4'd5;
      7'b0100000: w_seg_digit = 4'd6;
      7'b0001111: w_seg_digit = 4'd7;
      7'b0000000: w_seg_digit = 4'd8;
      7'b0000100: w_seg_digit = 4'd9;
      default:    w_seg_bad   = 1'b1;
    endcase
  end

  // Stability counter next state and single-shot capture strobe.
  always_comb begin
    w_same    = (bus.Anode == r_anode_prev) && (bus.LED_out == r_seg_prev);
    w_cnt_d   = 8'd0;
    w_capture = 1'b0;
    if (w_slot_legal) begin
      if (!w_same) begin
        w_cnt_d = 8'd1;
      end else if (r_cnt >= SettleVal) begin
        w_cnt_d = SettleVal;
      end else begin
        w_cnt_d = r_cnt + 8'd1;
      end
      // Fire only on the transition into the settled count, not while saturated.
      w_capture = (w_cnt_d == SettleVal) && !(w_same && (r_cnt == SettleVal));
    end
  end

  // Sample registers and stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_anode_prev <= 4'd0;
      r_seg_prev   <= 7'd0;
      r_cnt        <= 8'd0;
    end else begin
      r_anode_prev <= bus.Anode;
      r_seg_prev   <= bus.LED_out;
      r_cnt        <= w_cnt_d;
    end
  end

  // Seen mask and sticky error: frame start clears them, a same-edge capture still lands.
  always_comb begin
    w_seen_d       = w_frame_start ? 4'd0 : r_seen;
    w_err_sticky_d = w_frame_start ? 1'b0 : r_err_sticky;
    if (w_capture) begin
      w_seen_d[w_slot_idx] = 1'b1;
      if (w_seg_bad) begin
        w_err_sticky_d = 1'b1;
      end
    end
  end

  // Digit registers, seen mask and sticky frame error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_digit[i] <= 4'd0;
      end
      r_seen       <= 4'd0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_capture) begin
        r_digit[w_slot_idx] <= w_seg_digit;
      end
      r_seen       <= w_seen_d;
      r_err_sticky <= w_err_sticky_d;
    end
  end

  // acc*10 + digit, with *10 as two shifts; 9999 fits in 14 bits so no overflow.
  assign w_mac = (r_acc << 3) + (r_acc << 1) + {10'd0, r_snap[r_step]};

  assign w_frame_start = (r_state == StCollect) && (r_seen == 4'hF);

  // FSM next state, accumulator steps and result registration.
  always_comb begin
    w_state_d     = r_state;
    w_acc_d       = r_acc;
    w_step_d      = r_step;
    w_num_out_d   = r_num_out;
    w_num_valid_d = 1'b0;
    w_changed_d   = r_changed;
    w_seg_err_d   = r_seg_err;
    w_range_err_d = r_range_err;
    w_first_d     = r_first;
    case (r_state)
      StCollect: begin
        if (w_frame_start) begin
          w_acc_d   = 14'd0;
          w_step_d  = 2'd0;
          w_state_d = StConvert;
        end
      end
      StConvert: begin
        w_acc_d  = w_mac;
        w_step_d = r_step + 2'd1;
        if (r_step == 2'd3) begin
          w_num_out_d   = w_mac;
          w_num_valid_d = 1'b1;
          w_changed_d   = r_first || (w_mac != r_num_out);
          w_seg_err_d   = r_snap_err;
          w_range_err_d = (w_mac > 14'd8191);
          w_first_d     = 1'b0;
          w_state_d     = StCollect;
        end
      end
      default: w_state_d = StCollect;
    endcase
  end

  // FSM state, frame snapshot, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StCollect;
      for (int i = 0; i < 4; i++) begin
        r_snap[i] <= 4'd0;
      end
      r_snap_err  <= 1'b0;
      r_acc       <= 14'd0;
      r_step      <= 2'd0;
      r_num_out   <= 14'd0;
      r_num_valid <= 1'b0;
      r_changed   <= 1'b0;
      r_seg_err   <= 1'b0;
      r_range_err <= 1'b0;
      r_first     <= 1'b1;
    end else begin
      if (w_frame_start) begin
        for (int i = 0; i < 4; i++) begin
          r_snap[i] <= r_digit[i];
        end
        r_snap_err <= r_err_sticky;
      end
      r_state     <= w_state_d;
      r_acc       <= w_acc_d;
      r_step      <= w_step_d;
      r_num_out   <= w_num_out_d;
      r_num_valid <= w_num_valid_d;
      r_changed   <= w_changed_d;
      r_seg_err   <= w_seg_err_d;
      r_range_err <= w_range_err_d;
      r_first     <= w_first_d;
    end
  end

  assign bus.num_out   = r_num_out;
  assign bus.num_valid = r_num_valid;
  assign bus.changed   = r_changed;
  assign bus.seg_err   = r_seg_err;
  assign bus.range_err = r_range_err;

endmodule

// File: tb/tb_seven_segment_capture_decoder.sv
// Scoreboard bench for seven_segment_capture_decoder: a display driver model issues frames
// and pushes expected results; a negedge monitor pops and compares on each num_valid.
module tb_seven_segment_capture_decoder;

  localparam int unsigned Settle = 4;
  localparam logic [6:0] SegTab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                         7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                         7'b0000000, 7'b0000100};

  typedef struct {
    int value;
    bit changed;
    bit seg_err;
    bit range_err;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_segment_capture_decoder_if u_if ();

  seven_segment_capture_decoder #(
    .SETTLE_CYCLES(Settle)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_num = 0;
  int   model_prev = 0;
  bit   model_first = 1'b1;
  bit   prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per num_valid; between pulses num_out must hold.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (u_if.num_valid) begin
        check("valid_one_cycle", int'(prev_valid), 0);
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("num_out", int'(u_if.num_out), mon_e.value);
          check("changed", int'(u_if.changed), int'(mon_e.changed));
          check("seg_err", int'(u_if.seg_err), int'(mon_e.seg_err));
          check("range_err", int'(u_if.range_err), int'(mon_e.range_err));
          check("latency", cyc, mon_e.cyc);
          last_num = mon_e.value;
        end
      end else begin
        check("num_hold", int'(u_if.num_out), last_num);
      end
      prev_valid = u_if.num_valid;
    end
  end

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    u_if.Anode   = a;
    u_if.LED_out = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] slot_anode(input int i);
    logic [3:0] a;
    a = 4'hF;
    a[3 - i] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] bad_pattern();
    logic [6:0] p;
    bit ok;
    for (int k = 0; k < 64; k++) begin
      p  = 7'($urandom_range(0, 127));
      ok = 1'b1;
      for (int j = 0; j < 10; j++) if (p == SegTab[j]) ok = 1'b0;
      if (ok) return p;
    end
    return 7'h7F;
  endfunction

  // One frame, thousands to ones. bad_mask bit i (i=0 thousands) replaces slot i with bad_pat.
  task automatic send_frame(input logic [15:0] bcd, input logic [3:0] bad_mask,
                            input logic [6:0] bad_pat, input int dwell, input int blank,
                            input bit decoy, input bit abort);
    int   val;
    bit   err;
    int   dig;
    exp_t e;
    logic [6:0] pat;
    val = 0;
    err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dig = int'(bcd[15 - 4 * i -: 4]);
      pat = bad_mask[i] ? bad_pat : SegTab[dig];
      val = val * 10 + (bad_mask[i] ? 0 : dig);
      err = err | bad_mask[i];
      if (i == 0 && decoy) drive(slot_anode(0), SegTab[(dig + 1) % 10], dwell);
      if (i == 3) begin
        if (abort) begin
          drive(slot_anode(3), pat, Settle);
          drive(4'hF, 7'h7F, 1);
          repeat (2) @(posedge clk);
          #1;
          rst = 1'b1;
          last_num = 0;
          model_first = 1'b1;
          repeat (2) @(posedge clk);
          #1;
          rst = 1'b0;
          check("abort_num_out", int'(u_if.num_out), 0);
          check("abort_valid", int'(u_if.num_valid), 0);
          check("abort_flags", int'({u_if.changed, u_if.seg_err, u_if.range_err}), 0);
          return;
        end
        e.value     = val;
        e.seg_err   = err;
        e.range_err = (val > 8191);
        e.changed   = model_first || (val != model_prev);
        e.cyc       = cyc + Settle + 5;
        model_prev  = val;
        model_first = 1'b0;
        sb_q.push_back(e);
      end
      drive(slot_anode(i), pat, dwell);
      if (i < 3 && blank > 0) drive(4'hF, 7'h7F, blank);
    end
    drive(4'hF, 7'h7F, blank + 1);
  endtask

  initial begin
    u_if.Anode   = 4'hF;
    u_if.LED_out = 7'h7F;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_num_out", int'(u_if.num_out), 0);
    check("rst_valid", int'(u_if.num_valid), 0);
    check("rst_flags", int'({u_if.changed, u_if.seg_err, u_if.range_err}), 0);
    rst = 1'b0;

    // Short dwells never settle: nothing expected.
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++) drive(slot_anode(i), SegTab[i + 1], 3);
    drive(4'hF, 7'h7F, 10);
    check("short_dwell_num_out", int'(u_if.num_out), 0);

    send_frame(16'h1234, 4'b0000, 7'h7F, 16, 0, 1'b0, 1'b0);
    send_frame(16'h9999, 4'b0000, 7'h7F, 16, 0, 1'b0, 1'b0);
    send_frame(16'h8191, 4'b0000, 7'h7F, 16, 0, 1'b0, 1'b0);
    send_frame(16'h5007, 4'b0100, 7'h7F, 16, 0, 1'b0, 1'b0);
    send_frame(16'h5007, 4'b0000, 7'h7F, 16, 0, 1'b0, 1'b0);
    send_frame(16'h0123, 4'b0000, 7'h7F, 8, 0, 1'b0, 1'b1);
    send_frame(16'h0042, 4'b0000, 7'h7F, 8, 0, 1'b0, 1'b0);
    send_frame(16'h0703, 4'b0000, 7'h7F, 8, 3, 1'b0, 1'b0);
    send_frame(16'h0703, 4'b0000, 7'h7F, 8, 3, 1'b0, 1'b0);

    // Randomised frames with glitches, blanks, decoy overwrites and bad patterns.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] bcd;
      logic [3:0]  bmask;
      for (int i = 0; i < 4; i++) bcd[15 - 4 * i -: 4] = 4'($urandom_range(0, 9));
      bmask = ($urandom_range(0, 4) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      if ($urandom_range(0, 2) == 0) begin
        drive(slot_anode($urandom_range(0, 3)), SegTab[$urandom_range(0, 9)], Settle - 1);
        drive(4'hF, 7'h7F, 1);
      end
      send_frame(bcd, bmask, bad_pattern(), Settle + $urandom_range(0, 6),
                 $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b0);
    end

    for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
